// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned DefaultWidth     = 4;
  localparam int unsigned DefaultPrescaleW = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: emits a single-cycle tick every prescale+1 enabled cycles.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PreOne = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

  // >= so that lowering prescale mid-run fires on the next enabled cycle
  assign tick = en && (pre_cnt_q >= prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PreOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, prescaled ticks, load and wrap/saturate modes.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned PRESCALE_W = DefaultPrescaleW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  mode_sat,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  at_max,
  output logic                  at_min
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             sat;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign sat = (mode_sat == MODE_SAT);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
    end else if (tick) begin
      if (count_q > limit) begin
        // limit was lowered under the count: snap back into range silently
        count_d = limit;
      end else if (up) begin
        if (count_q < limit) begin
          count_d = count_q + One;
          tc_d    = sat && ((count_q + One) == limit);
        end else if (!sat) begin
          count_d = '0;
          tc_d    = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - One;
          tc_d    = sat && (count_q == One);
        end else if (!sat) begin
          count_d = limit;
          tc_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign at_max = (count_q == limit);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: directed plan steps plus random traffic against an integer model.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit instance, checked every edge against the model
  logic       rst, en, up, load, mode_sat;
  logic [3:0] load_val, limit;
  logic [7:0] prescale;
  logic [3:0] count;
  logic       tc, at_max, at_min;

  // 8-bit instance for the width extreme
  logic       rst8, en8, up8, load8, sat8;
  logic [7:0] load_val8, limit8, prescale8;
  logic [7:0] count8;
  logic       tc8, at_max8, at_min8;

  int total = 0;
  int bad   = 0;

  int m_count, m_tc, m_pre;

  updown_counter_mod dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode_sat (mode_sat),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  updown_counter_mod #(
    .WIDTH      (8),
    .PRESCALE_W (8)
  ) dut8 (
    .clk      (clk),
    .rst      (rst8),
    .en       (en8),
    .up       (up8),
    .load     (load8),
    .load_val (load_val8),
    .limit    (limit8),
    .mode_sat (sat8),
    .prescale (prescale8),
    .count    (count8),
    .tc       (tc8),
    .at_max   (at_max8),
    .at_min   (at_min8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: a tick moves one step toward a target; leaving 0..limit is a
  // boundary event (wrap to the far end, or refuse to move when saturating).
  task automatic model_update();
    int  lim;
    int  tgt;
    bit  tick;
    lim = int'(limit);
    if (rst) begin
      m_count = 0; m_tc = 0; m_pre = 0;
    end else if (load) begin
      m_count = (int'(load_val) > lim) ? lim : int'(load_val);
      m_pre   = 0;
      m_tc    = 0;
    end else begin
      tick = en && (m_pre >= int'(prescale));
      if (en) m_pre = tick ? 0 : m_pre + 1;
      m_tc = 0;
      if (tick) begin
        tgt = up ? m_count + 1 : m_count - 1;
        if (m_count > lim) begin
          m_count = lim;
        end else if (tgt > lim || tgt < 0) begin
          if (!mode_sat) begin
            m_count = up ? 0 : lim;
            m_tc    = 1;
          end
        end else begin
          m_count = tgt;
          m_tc    = (mode_sat && (tgt == 0 || tgt == lim)) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("count", count, m_count);
    chk("tc", tc, m_tc);
    chk("at_max", at_max, m_count == int'(limit));
    chk("at_min", at_min, m_count == 0);
  endtask

  initial begin
    rst = 1; en = 0; up = 1; load = 0; mode_sat = 0;
    load_val = 0; limit = 4'd9; prescale = 0;
    rst8 = 1; en8 = 0; up8 = 0; load8 = 0; sat8 = 0;
    load_val8 = 0; limit8 = 8'd255; prescale8 = 0;
    m_count = 0; m_tc = 0; m_pre = 0;

    // Reset state
    step();
    chk("rst_at_min", at_min, 1);
    chk("rst_count", count, 0);

    // Wrap run 0..9 then 0 with tc
    rst = 0; en = 1;
    repeat (9) step();
    chk("wrap_top", count, 9);
    step();
    chk("wrap_zero", count, 0);
    chk("wrap_tc", tc, 1);
    step();
    chk("wrap_tc_clear", tc, 0);

    // Prescale 3 with an enable gap of 2 cycles
    prescale = 8'd3;
    repeat (4) step();
    chk("pre_step", count, 2);
    en = 0;
    repeat (2) step();
    en = 1;
    repeat (3) step();
    chk("pre_gap_hold", count, 2);
    step();
    chk("pre_gap_step", count, 3);

    // Saturating count-down from 2
    load = 1; load_val = 4'd2; limit = 4'd5; mode_sat = 1; up = 0; prescale = 0;
    step();
    load = 0;
    step();
    chk("sat_1", count, 1);
    step();
    chk("sat_0", count, 0);
    chk("sat_tc", tc, 1);
    step();
    chk("sat_hold", count, 0);
    chk("sat_hold_tc", tc, 0);

    // Load clamping and priority
    load = 1; load_val = 4'd12; limit = 4'd7; en = 0;
    step();
    chk("load_clamp", count, 7);
    chk("load_at_max", at_max, 1);
    en = 1; load_val = 4'd3;
    step();
    chk("load_over_tick", count, 3);
    rst = 1;
    step();
    chk("rst_over_load", count, 0);
    rst = 0;

    // Limit lowered below the count
    load = 1; load_val = 4'd6; up = 1; mode_sat = 0; en = 0;
    step();
    load = 0; limit = 4'd3;
    #1;
    chk("oor_at_max", at_max, 0);
    step();
    chk("oor_hold", count, 6);
    en = 1;
    step();
    chk("oor_snap", count, 3);
    chk("oor_tc", tc, 0);
    step();
    chk("oor_wrap", count, 0);
    chk("oor_wrap_tc", tc, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(99) < 2);
      load     = ($urandom_range(99) < 6);
      load_val = 4'($urandom);
      en       = ($urandom_range(3) != 0);
      up       = 1'($urandom_range(1));
      if ($urandom_range(9) == 0)  limit    = 4'($urandom);
      if ($urandom_range(9) == 0)  mode_sat = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) prescale = 8'($urandom_range(3));
      step();
    end
    rst = 0; load = 0; en = 0;

    // 8-bit extreme: down from 0 wraps to 255
    step();
    rst8 = 0; en8 = 1;
    step();
    chk("w8_count", count8, 255);
    chk("w8_tc", tc8, 1);
    chk("w8_at_max", at_max8, 1);
    up8 = 1;
    step();
    chk("w8_up_wrap", count8, 0);
    chk("w8_up_tc", tc8, 1);
    sat8 = 1; up8 = 0;
    step();
    chk("w8_sat_hold", count8, 0);
    chk("w8_sat_tc", tc8, 0);
    chk("w8_at_min", at_min8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised up/down counter with programmable modulus, tick prescaler, synchronous load, and wrap or saturate overflow behaviour. It generalises the team's fixed 4-bit up/down counter. It sits behind the `ui_in` control bits of a user project and drives `uo_out`. Other blocks can use `tc` as a cascade or event source.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits (≥2).
- `PRESCALE_W`, default 8: prescaler compare width in bits (≥1).

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: count enable; gates the prescaler.
- `up`  in  1: direction; 1 = increment, 0 = decrement. Sampled on each tick.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  WIDTH: value to load.
- `limit`  in  WIDTH: modulus maximum; the count range is 0..`limit`.
- `mode_sat`  in  1: overflow mode; 0 = wrap, 1 = saturate.
- `prescale`  in  PRESCALE_W: a tick fires every `prescale`+1 enabled cycles.
- `count`  out  WIDTH: current count, registered.
- `tc`  out  1: terminal-count pulse, registered, one cycle wide.
- `at_max`  out  1: combinational, `count == limit`.
- `at_min`  out  1: combinational, `count == 0`.

## Operation
- Priority on each edge: `rst` first, then `load`, then tick step, then hold.
- Reset values:
  - `count` = 0, `tc` = 0, prescaler count = 0.
  - Hence `at_min` = 1 and `at_max` = (`limit` == 0).
- Prescaler:
  - Internal `pre_cnt` is PRESCALE_W bits wide.
  - With `en` = 1: if `pre_cnt` >= `prescale`, then tick = 1 and `pre_cnt` <= 0; otherwise `pre_cnt` increments.
  - With `en` = 0: `pre_cnt` holds and no tick fires.
  - The >= compare makes a mid-run decrease of `prescale` fire on the next enabled cycle.
- Load:
  - `count` <= min(`load_val`, `limit`), `pre_cnt` <= 0, `tc` <= 0.
  - Load takes effect regardless of `en`.
- Tick step with `up` = 1:
  - `count` < `limit`: `count` + 1.
  - `count` == `limit`, wrap mode: `count` <= 0, `tc` <= 1.
  - `count` == `limit`, saturate mode: hold, `tc` <= 0.
- Tick step with `up` = 0:
  - `count` > 0: `count` − 1.
  - `count` == 0, wrap mode: `count` <= `limit`, `tc` <= 1.
  - `count` == 0, saturate mode: hold, `tc` <= 0.
- Saturate-mode `tc`: pulses on the tick that moves `count` onto the boundary (reaches `limit` going up, reaches 0 going down). It stays 0 while holding at the boundary.
- Out-of-range count:
  - Applies when `limit` has been lowered below the current `count`.
  - The next tick forces `count` <= `limit` in either mode and direction, with `tc` = 0.
  - Between ticks the count holds and `at_max` reads 0.
- `limit` = 0: `count` is stuck at 0.
  - Wrap mode: `tc` pulses on every tick.
  - Saturate mode: `tc` never pulses.
- All arithmetic is modulo 2^WIDTH internally. The compare logic guarantees no native overflow is ever visible.

## Timing
- Tick-to-count latency is 1 cycle. `count` and `tc` change on the edge where the tick is evaluated.
- After reset or load, with `en` held at 1, the first step lands on the (`prescale`+1)th edge.
- `tc` is high for exactly one cycle per qualifying tick. It is cleared on every non-qualifying edge.
- `load` and `rst` take effect on the next edge. Asserting them mid-prescale discards the partial prescale count.
- `up`, `limit` and `mode_sat` may change on any cycle. Only their values on a tick edge matter.

## Structure
- Shared package `counter_pkg`:
  - mode encoding constants `MODE_WRAP` = 0 and `MODE_SAT` = 1;
  - default `WIDTH` and `PRESCALE_W` constants.
- Sub-module `tick_prescaler`:
  - parameter PRESCALE_W;
  - ports `clk`, `rst`, `en`, `clr`, `prescale`, `tick`.
  - Top-level `load` drives `clr`.
- The top level holds the count register, next-value mux, and `tc` register.
- `at_min` and `at_max` are plain comparators.

## Test plan
- Reset, then `en` = 1, `up` = 1, `prescale` = 0, `limit` = 9, wrap mode: `count` runs 0..9, then 0 on the 11th edge. `tc` is high only in that cycle.
- `prescale` = 3, `up` = 1: `count` increments on every 4th edge. Dropping `en` for 2 cycles delays the next step by exactly 2 edges.
- Saturate mode, `limit` = 5, `up` = 0 from count 2: `count` goes 1, 0 (`tc` = 1 on the edge reaching 0), then holds at 0 with `tc` = 0 and `at_min` = 1.
- `load` with `load_val` = 12, `limit` = 7: `count` = 7 and `at_max` = 1. A simultaneous tick and `load` yields the load value. Asserting `rst` together with `load` yields 0.
- Count = 6, `limit` changed to 3: `at_max` = 0 until the next tick, then `count` = 3 and `tc` = 0. A subsequent up tick in wrap mode gives 0 with `tc` = 1.
- `WIDTH` = 8, `limit` = 255, wrap mode, `up` = 0 from 0: `count` = 255 with `tc` = 1. No X propagation at the parameter extremes.
